// File: rtl/cpu_executor_if.sv
// ============================================================================
// Module      : cpu_executor_if
// Description : Sequencer, RAM and output-port signals of the CPU executor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_executor_if #(
    parameter int DATA_W = 8
);
    logic [3:0]        state;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              halted;
    logic              reset_cycle;

    // Sequencer / RAM / environment side
    modport master (
        output state, mem_rdata,
        input  opcode, mem_addr, mem_wdata, mem_we,
        input  out_data, out_valid, halted, reset_cycle
    );

    // Executor side
    modport slave (
        input  state, mem_rdata,
        output opcode, mem_addr, mem_wdata, mem_we,
        output out_data, out_valid, halted, reset_cycle
    );
endinterface

`default_nettype wire

// File: rtl/cpu_executor.sv
// ============================================================================
// Module      : cpu_executor
// Description : Executes sequencer state codes on PC/IR/MAR/A/B/Z registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_executor #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] PC_RESET = '0
) (
    input  wire          clk,
    input  wire          reset,
    cpu_executor_if.slave bus
);
    localparam logic [3:0] c_ST_NEXT       = 4'd0;
    localparam logic [3:0] c_ST_FETCH_PC   = 4'd1;
    localparam logic [3:0] c_ST_FETCH_INST = 4'd2;
    localparam logic [3:0] c_ST_HALT       = 4'd3;
    localparam logic [3:0] c_ST_JUMP       = 4'd4;
    localparam logic [3:0] c_ST_OUT_A      = 4'd5;
    localparam logic [3:0] c_ST_LOAD_ADDR  = 4'd6;
    localparam logic [3:0] c_ST_RAM_A      = 4'd7;
    localparam logic [3:0] c_ST_RAM_B      = 4'd8;
    localparam logic [3:0] c_ST_ALU_OP     = 4'd9;
    localparam logic [3:0] c_ST_STORE_A    = 4'd10;

    localparam logic [3:0] c_OP_ADD = 4'd2;
    localparam logic [3:0] c_OP_SUB = 4'd3;
    localparam logic [3:0] c_OP_JMP = 4'd6;
    localparam logic [3:0] c_OP_JEZ = 4'd7;
    localparam logic [3:0] c_OP_JNZ = 4'd8;

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_mar;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_out_data;
    logic [3:0]        r_ir;
    logic              r_z;
    logic              r_mem_we;
    logic              r_out_valid;
    logic              r_halted;
    logic              r_reset_cycle;

    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_en;
    logic              w_jump_take;

    always_comb begin
        w_alu_res = r_a;
        w_alu_en  = 1'b0;
        case (r_ir)
            c_OP_ADD: begin
                w_alu_res = r_a + r_b;
                w_alu_en  = 1'b1;
            end
            c_OP_SUB: begin
                w_alu_res = r_a - r_b;
                w_alu_en  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_jump_take = 1'b0;
        case (r_ir)
            c_OP_JMP: w_jump_take = 1'b1;
            c_OP_JEZ: w_jump_take = r_z;
            c_OP_JNZ: w_jump_take = ~r_z;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= PC_RESET;
            r_mar         <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_out_data    <= '0;
            r_ir          <= '0;
            r_z           <= 1'b0;
            r_mem_we      <= 1'b0;
            r_out_valid   <= 1'b0;
            r_halted      <= 1'b0;
            r_reset_cycle <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-triggered below
            r_mem_we      <= 1'b0;
            r_out_valid   <= 1'b0;
            r_reset_cycle <= 1'b0;
            if (!r_halted) begin
                case (bus.state)
                    c_ST_NEXT:       r_reset_cycle <= 1'b1;
                    c_ST_FETCH_PC: begin
                        r_mar <= r_pc;
                        r_pc  <= r_pc + 1'b1;
                    end
                    c_ST_FETCH_INST: r_ir <= bus.mem_rdata[7:4];
                    c_ST_HALT:       r_halted <= 1'b1;
                    c_ST_JUMP: begin
                        if (w_jump_take) begin
                            r_pc <= bus.mem_rdata;
                        end
                    end
                    c_ST_OUT_A: begin
                        r_out_data  <= r_a;
                        r_out_valid <= 1'b1;
                    end
                    c_ST_LOAD_ADDR:  r_mar <= bus.mem_rdata;
                    c_ST_RAM_A: begin
                        r_a <= bus.mem_rdata;
                        r_z <= (bus.mem_rdata == '0);
                    end
                    c_ST_RAM_B:      r_b <= bus.mem_rdata;
                    c_ST_ALU_OP: begin
                        if (w_alu_en) begin
                            r_a <= w_alu_res;
                            r_z <= (w_alu_res == '0);
                        end
                    end
                    c_ST_STORE_A:    r_mem_we <= 1'b1;
                    default:         ;
                endcase
            end
        end
    end

    assign bus.opcode      = r_ir;
    assign bus.mem_addr    = r_mar;
    assign bus.mem_wdata   = r_a;
    assign bus.mem_we      = r_mem_we;
    assign bus.out_data    = r_out_data;
    assign bus.out_valid   = r_out_valid;
    assign bus.halted      = r_halted;
    assign bus.reset_cycle = r_reset_cycle;

endmodule

`default_nettype wire

// File: tb/tb_cpu_executor.sv
// ============================================================================
// Module      : tb_cpu_executor
// Description : Plays sequencer and RAM for cpu_executor against an
//               instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_executor;
    localparam logic [3:0] ST_NEXT = 4'd0, ST_FETCH_PC = 4'd1, ST_FETCH_INST = 4'd2,
                           ST_HALT = 4'd3, ST_JUMP = 4'd4, ST_OUT_A = 4'd5,
                           ST_LOAD_ADDR = 4'd6, ST_RAM_A = 4'd7, ST_RAM_B = 4'd8,
                           ST_ALU_OP = 4'd9, ST_STORE_A = 4'd10, ST_IDLE = 4'd11;
    localparam logic [3:0] OP_NOP = 4'd0, OP_LDA = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
                           OP_STA = 4'd4, OP_OUT = 4'd5, OP_JMP = 4'd6, OP_JEZ = 4'd7,
                           OP_JNZ = 4'd8, OP_HLT = 4'd15;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    cpu_executor_if #(.DATA_W(8)) bus ();

    cpu_executor #(.DATA_W(8), .PC_RESET(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram     [256];
    logic [7:0] exp_mem [256];
    assign bus.mem_rdata = ram[bus.mem_addr];

    // Reference model state, instruction granularity
    logic [7:0] m_pc;
    logic [7:0] m_a;
    logic       m_z;

    int errors = 0;
    int checks = 0;
    int n_rc, n_ov, n_we;
    logic [7:0] ov_data, we_addr, we_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_mem(input logic [7:0] addr, input logic [7:0] val);
        ram[addr]     = val;
        exp_mem[addr] = val;
    endtask

    // One sequencer cycle; the RAM commits a pending write on the same edge.
    task automatic step(input logic [3:0] s);
        logic       we;
        logic [7:0] wa, wd;
        bus.state = s;
        we = bus.mem_we;
        wa = bus.mem_addr;
        wd = bus.mem_wdata;
        @(posedge clk);
        if (we === 1'b1) ram[wa] = wd;
        #1;
        if (bus.reset_cycle === 1'b1) n_rc++;
        if (bus.out_valid === 1'b1) begin
            n_ov++;
            ov_data = bus.out_data;
        end
        if (bus.mem_we === 1'b1) begin
            n_we++;
            we_addr = bus.mem_addr;
            we_data = bus.mem_wdata;
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00;
        m_a  = 8'h00;
        m_z  = 1'b0;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [7:0] opnd);
        logic       has_opnd;
        logic [7:0] p1;
        has_opnd = !(op inside {OP_NOP, OP_OUT, OP_HLT});
        p1 = m_pc + 8'd1;
        set_mem(m_pc, {op, 4'h0});
        if (has_opnd) set_mem(p1, opnd);
        n_rc = 0; n_ov = 0; n_we = 0;

        step(ST_FETCH_PC);
        chk("pc_fetch", bus.mem_addr, m_pc);
        step(ST_FETCH_INST);
        chk("opcode", bus.opcode, op);
        m_pc = m_pc + 8'd1;
        if (has_opnd) m_pc = m_pc + 8'd1;

        case (op)
            OP_LDA: begin
                step(ST_FETCH_PC); step(ST_LOAD_ADDR); step(ST_RAM_A); step(ST_NEXT);
                m_a = exp_mem[opnd];
                m_z = (m_a == 8'h00);
            end
            OP_ADD, OP_SUB: begin
                step(ST_FETCH_PC); step(ST_LOAD_ADDR); step(ST_RAM_B); step(ST_ALU_OP);
                step(ST_NEXT);
                m_a = (op == OP_ADD) ? m_a + exp_mem[opnd] : m_a - exp_mem[opnd];
                m_z = (m_a == 8'h00);
            end
            OP_STA: begin
                step(ST_FETCH_PC); step(ST_LOAD_ADDR); step(ST_STORE_A); step(ST_NEXT);
                exp_mem[opnd] = m_a;
            end
            OP_OUT: begin
                step(ST_OUT_A); step(ST_NEXT);
            end
            OP_JMP, OP_JEZ, OP_JNZ: begin
                step(ST_FETCH_PC); step(ST_JUMP); step(ST_NEXT);
                if (op == OP_JMP || (op == OP_JEZ && m_z) || (op == OP_JNZ && !m_z))
                    m_pc = opnd;
            end
            OP_HLT: step(ST_HALT);
            default: step(ST_NEXT);
        endcase

        chk("acc", bus.mem_wdata, m_a);
        chk("halted", bus.halted, (op == OP_HLT));
        chk("n_reset_cycle", n_rc, (op == OP_HLT) ? 0 : 1);
        chk("n_out_valid", n_ov, (op == OP_OUT) ? 1 : 0);
        chk("n_mem_we", n_we, (op == OP_STA) ? 1 : 0);
        if (n_ov == 1) chk("out_data", ov_data, m_a);
        if (n_we == 1) begin
            chk("we_addr", we_addr, opnd);
            chk("we_data", we_data, m_a);
            chk("ram_commit", ram[opnd], exp_mem[opnd]);
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_opcode"},    bus.opcode, 4'h0);
        chk({tag, "_mem_addr"},  bus.mem_addr, 8'h00);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 8'h00);
        chk({tag, "_out_data"},  bus.out_data, 8'h00);
        chk({tag, "_strobes"},   {bus.mem_we, bus.out_valid, bus.reset_cycle}, 3'b000);
        chk({tag, "_halted"},    bus.halted, 1'b0);
    endtask

    initial begin
        logic [7:0] frz_addr;
        bus.state = ST_IDLE;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            set_mem(8'(i), v);
        end
        model_reset();

        // Reset state
        #12;
        check_cleared("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // LDA / OUT
        set_mem(8'h20, 8'h5A); set_mem(8'h21, 8'hF0); set_mem(8'h22, 8'h20);
        set_mem(8'h23, 8'h10); set_mem(8'h24, 8'h01); set_mem(8'h25, 8'h7E);
        run_instr(OP_LDA, 8'h20);
        chk("lda_5a", bus.mem_wdata, 8'h5A);
        run_instr(OP_OUT, 8'h00);
        chk("out_5a", bus.out_data, 8'h5A);

        // ALU with wrap, then zero result
        run_instr(OP_LDA, 8'h21);
        run_instr(OP_ADD, 8'h22);
        chk("add_wrap", bus.mem_wdata, 8'h10);
        run_instr(OP_SUB, 8'h23);
        chk("sub_zero", bus.mem_wdata, 8'h00);

        // Conditional jumps
        run_instr(OP_JEZ, 8'h40);
        chk("jez_taken_pc", m_pc, 8'h40);
        run_instr(OP_JNZ, 8'h80);
        chk("jnz_not_taken_pc", m_pc, 8'h42);
        run_instr(OP_LDA, 8'h24);
        run_instr(OP_JNZ, 8'h80);

        // Store
        run_instr(OP_LDA, 8'h25);
        run_instr(OP_STA, 8'h33);
        chk("sta_ram", ram[8'h33], 8'h7E);

        // PC wrap: instruction at 0xFF, operand at 0x00
        run_instr(OP_JMP, 8'hFF);
        run_instr(OP_LDA, 8'h20);
        run_instr(OP_NOP, 8'h00);

        // Halt freezes everything
        run_instr(OP_HLT, 8'h00);
        frz_addr = bus.mem_addr;
        n_rc = 0; n_ov = 0; n_we = 0;
        step(ST_FETCH_PC); step(ST_RAM_A); step(ST_NEXT);
        step(ST_OUT_A); step(ST_STORE_A); step(ST_ALU_OP);
        chk("halt_mar", bus.mem_addr, frz_addr);
        chk("halt_acc", bus.mem_wdata, m_a);
        chk("halt_strobes", n_rc + n_ov + n_we, 0);
        chk("halt_sticky", bus.halted, 1'b1);

        // Asynchronous reset while halted
        bus.state = ST_IDLE;
        #3 reset = 1'b1;
        #1 check_cleared("rst_halted");
        #2 reset = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // Asynchronous reset in the middle of ALU_OP
        set_mem(8'h50, 8'h33); set_mem(8'h51, 8'h11);
        run_instr(OP_LDA, 8'h50);
        set_mem(m_pc, {OP_ADD, 4'h0});
        set_mem(m_pc + 8'd1, 8'h51);
        step(ST_FETCH_PC); step(ST_FETCH_INST); step(ST_FETCH_PC);
        step(ST_LOAD_ADDR); step(ST_RAM_B);
        bus.state = ST_ALU_OP;
        #3 reset = 1'b1;
        #1 check_cleared("rst_alu");
        @(posedge clk); #1;
        check_cleared("rst_alu_held");
        bus.state = ST_IDLE;
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // Randomized instruction stream
        for (int k = 0; k < 80; k++) begin
            logic [3:0] ops [9];
            ops = '{OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_OUT, OP_JMP, OP_JEZ, OP_JNZ};
            run_instr(ops[$urandom_range(0, 8)], 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
